// File: rtl/multiword_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// multiword_add_ctrl_if
//   Bundles the request/result signals of multiword_add_ctrl.
//   Optional macro: MULTIWORD_ADD_SUB_EN adds i_sub (subtract request).
//
//   i_start    request one wide operation
//   i_a_in     operand A            (32*WORDS bits)
//   i_b_in     operand B            (32*WORDS bits)
//   i_cin      carry into word 0
//   i_sub      1 = A - B            (only with MULTIWORD_ADD_SUB_EN)
//   o_busy     operation in progress
//   o_done     one-cycle result-valid pulse
//   o_sum_out  wide result          (32*WORDS bits)
//   o_cout     carry out of the top word
//
//   master: driver of requests (testbench / upstream logic)
//   slave : the adder controller
// -----------------------------------------------------------------------------
interface multiword_add_ctrl_if #(
    parameter int WORDS = 4
);
    logic                  i_start;
    logic [32*WORDS-1:0]   i_a_in;
    logic [32*WORDS-1:0]   i_b_in;
    logic                  i_cin;
`ifdef MULTIWORD_ADD_SUB_EN
    logic                  i_sub;
`endif
    logic                  o_busy;
    logic                  o_done;
    logic [32*WORDS-1:0]   o_sum_out;
    logic                  o_cout;

    modport master (
`ifdef MULTIWORD_ADD_SUB_EN
        output i_sub,
`endif
        output i_start, i_a_in, i_b_in, i_cin,
        input  o_busy, o_done, o_sum_out, o_cout
    );

    modport slave (
`ifdef MULTIWORD_ADD_SUB_EN
        input  i_sub,
`endif
        input  i_start, i_a_in, i_b_in, i_cin,
        output o_busy, o_done, o_sum_out, o_cout
    );
endinterface

// File: rtl/multiword_add_ctrl.sv
// -----------------------------------------------------------------------------
// multiword_add_ctrl
//   Wide (32*WORDS-bit) adder built from a single 32-bit add slice that is
//   reused once per clock, least-significant word first. One operation takes
//   WORDS RUN cycles plus one DONE cycle.
//
//   Optional macro: MULTIWORD_ADD_SUB_EN adds bus.i_sub; when set at capture
//   the block computes A + ~B + 1 (cin ignored, cout=1 means no borrow).
//
//   Ports:
//     clk  clock, rising edge
//     rst  asynchronous active-high reset
//     bus  multiword_add_ctrl_if.slave (start/operands in, busy/done/result out)
// -----------------------------------------------------------------------------
module multiword_add_ctrl #(
    parameter int WORDS = 4   // operand width in 32-bit words, 1..16
) (
    input  logic                       clk,
    input  logic                       rst,
    multiword_add_ctrl_if.slave        bus
);

    localparam int            KW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [32*WORDS-1:0]   r_a;
    logic [32*WORDS-1:0]   r_b;
    logic [32*WORDS-1:0]   r_sum;
    logic [KW-1:0]         r_k;
    logic                  r_carry;
    logic                  r_cout;
    logic                  r_busy;
    logic                  r_done;

    logic [31:0]           w_a_word;
    logic [31:0]           w_b_word;
    logic [31:0]           w_sum_word;
    logic                  w_carry_out;
    logic [32*WORDS-1:0]   w_b_capt;
    logic                  w_c_capt;

    // Subtraction is folded into the capture: store ~B and force the initial
    // carry to 1, so the RUN datapath is identical for add and subtract.
`ifdef MULTIWORD_ADD_SUB_EN
    assign w_b_capt = bus.i_sub ? ~bus.i_b_in : bus.i_b_in;
    assign w_c_capt = bus.i_sub ? 1'b1        : bus.i_cin;
`else
    assign w_b_capt = bus.i_b_in;
    assign w_c_capt = bus.i_cin;
`endif

    // The one shared 32-bit add slice, fed by the word selected by r_k.
    assign w_a_word = r_a[32*r_k +: 32];
    assign w_b_word = r_b[32*r_k +: 32];
    assign {w_carry_out, w_sum_word} = {1'b0, w_a_word} + {1'b0, w_b_word}
                                     + {32'd0, r_carry};

    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples the pre-edge values; blocking here would let the word
    // index update before the slice result is written back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            // NOTE: operand registers are reset too; they are plain flops (not
            // a RAM), so clearing them is cheap and keeps the datapath
            // deterministic out of reset.
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                // IDLE and DONE share acceptance; a new start in DONE chains
                // straight into RUN for back-to-back throughput.
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_a     <= bus.i_a_in;
                        r_b     <= w_b_capt;
                        r_carry <= w_c_capt;
                        r_k     <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                // start is not looked at here, so requests while busy drop.
                S_RUN: begin
                    r_sum[32*r_k +: 32] <= w_sum_word;
                    r_carry             <= w_carry_out;
                    if (r_k == K_LAST) begin
                        r_k     <= '0;
                        r_cout  <= w_carry_out;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_sum_out = r_sum;
    assign bus.o_cout    = r_cout;

endmodule
